fillcap_bank_seq: RTL and testbench



---
 rtl/fillcap_bank_pkg.sv | 25 ++
 rtl/fillcap_step_timer.sv | 36 +++
 rtl/fillcap_bank_seq.sv | 87 ++++++++
 tb/tb_fillcap_bank_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fillcap_bank_pkg.sv
// Shared types and helpers for the fillcap segment sequencer.
package fillcap_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    // Step timer width: enough bits to hold STEP_CYC-1, and never zero bits wide.
    function automatic int timer_w(input int step_cyc);
        return (step_cyc > 1) ? $clog2(step_cyc) : 1;
    endfunction

    // A request above the bank size asks for every segment.
    function automatic int unsigned clamp_tgt(input int unsigned tgt, input int unsigned n_seg);
        return (tgt > n_seg) ? n_seg : tgt;
    endfunction

    // One bit of the thermometer enable: segment idx is on when idx < cnt.
    function automatic logic therm_bit(input int unsigned idx, input int unsigned cnt);
        return idx < cnt;
    endfunction

endpackage

// File: rtl/fillcap_step_timer.sv
// Reloadable down-counter that paces segment changes.
// load wins over hold; otherwise the count falls and saturates at zero.
module fillcap_step_timer
    import fillcap_bank_pkg::*;
#(
    parameter  int STEP_CYC = 4,
    localparam int TW       = timer_w(STEP_CYC)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          hold_i,
    input  logic [TW-1:0] reload_i,
    output logic          zero_o
);

    logic [TW-1:0] timer_q, timer_d;

    // Next timer value: reload, freeze, or count down toward zero.
    always_comb begin
        timer_d = timer_q;
        if (load_i)
            timer_d = reload_i;
        else if (!hold_i && timer_q != '0)
            timer_d = timer_q - TW'(1);
    end

    // Timer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) timer_q <= '0;
        else         timer_q <= timer_d;
    end

    assign zero_o = (timer_q == '0);

endmodule

// File: rtl/fillcap_bank_seq.sv
// Slew-limited sequencer for a bank of fillcap decap segments.
// Walks a thermometer enable toward the latched target, one segment per
// STEP_CYC cycles. Upward steps pause while the supply is drooping; shedding
// capacitance is never blocked.
module fillcap_bank_seq
    import fillcap_bank_pkg::*;
#(
    parameter  int N_SEG    = 32,
    parameter  int STEP_CYC = 4,
    localparam int CW       = $clog2(N_SEG + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [CW-1:0]    target_i,
    input  logic             droop_i,
    output logic             ack_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CW-1:0]    count_o,
    output logic [N_SEG-1:0] en_o
);

    localparam int            TW     = timer_w(STEP_CYC);
    localparam logic [TW-1:0] RELOAD = TW'(STEP_CYC - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      tgt_q, tgt_d;
    logic [N_SEG-1:0]   en_q, en_d;
    logic               ack_q, done_q;
    logic               t_zero, t_hold, step;

    // Droop only freezes the interval while climbing.
    assign t_hold = droop_i && (state_q == ST_UP);
    assign step   = t_zero && (state_q != ST_IDLE) && !t_hold;

    fillcap_step_timer #(.STEP_CYC(STEP_CYC)) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (req_i || step),
        .hold_i   (t_hold),
        .reload_i (RELOAD),
        .zero_o   (t_zero)
    );

    // Step with the old target first, then let a new request take over;
    // the state follows the new count/target pair so BUSY never lags COUNT.
    always_comb begin
        count_d = count_q;
        if (step)
            count_d = (state_q == ST_UP) ? count_q + CW'(1) : count_q - CW'(1);
        tgt_d = req_i ? CW'(clamp_tgt(32'(target_i), N_SEG)) : tgt_q;
        state_d = ST_IDLE;
        if (count_d < tgt_d)      state_d = ST_UP;
        else if (count_d > tgt_d) state_d = ST_DOWN;
        en_d = '0;
        for (int i = 0; i < N_SEG; i++)
            en_d[i] = therm_bit(i, 32'(count_d));
    end

    // Registered state and outputs; EN is flopped so the switches see clean edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tgt_q   <= '0;
            en_q    <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tgt_q   <= tgt_d;
            en_q    <= en_d;
            ack_q   <= req_i;
            done_q  <= (step || req_i) && (count_d == tgt_d);
        end
    end

    assign ack_o   = ack_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign count_o = count_q;
    assign en_o    = en_q;

endmodule

// File: tb/tb_fillcap_bank_seq.sv
// Bench for fillcap_bank_seq: event-time reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fillcap_bank_seq;

    localparam int N   = 32;
    localparam int SC  = 4;
    localparam int N2  = 8;
    localparam int SC2 = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, droop;
    logic [5:0]  target;
    logic        ack, busy, done;
    logic [5:0]  count;
    logic [31:0] en;

    logic        req2, droop2;
    logic [3:0]  target2;
    logic        ack2, busy2, done2;
    logic [3:0]  count2;
    logic [7:0]  en2;

    int nvec = 0;
    int nerr = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    fillcap_bank_seq #(.N_SEG(N), .STEP_CYC(SC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .target_i(target), .droop_i(droop),
        .ack_o(ack), .busy_o(busy), .done_o(done), .count_o(count), .en_o(en)
    );

    fillcap_bank_seq #(.N_SEG(N2), .STEP_CYC(SC2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .target_i(target2), .droop_i(droop2),
        .ack_o(ack2), .busy_o(busy2), .done_o(done2), .count_o(count2), .en_o(en2)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the edge index at which the next step lands.
    int m_count, m_tgt, m_ns, ecnt;
    bit m_ack, m_done;

    always @(posedge clk or negedge rst_n) begin : mdl
        int c, t, ns, dir, tv;
        bit st;
        if (!rst_n) begin
            m_count <= 0; m_tgt <= 0; m_ns <= 0; ecnt <= 0;
            m_ack <= 1'b0; m_done <= 1'b0;
        end else begin
            c = m_count; t = m_tgt; ns = m_ns; st = 1'b0;
            dir = (t > c) ? 1 : (t < c) ? -1 : 0;
            if (dir > 0 && droop) begin
                ns = ns + 1;
            end else if (dir != 0 && ecnt == ns) begin
                c = c + dir; ns = ecnt + SC; st = 1'b1;
            end
            if (req) begin
                tv = int'(target);
                t  = (tv > N) ? N : tv;
                ns = ecnt + SC;
            end
            m_count <= c; m_tgt <= t; m_ns <= ns; ecnt <= ecnt + 1;
            m_ack  <= req;
            m_done <= (st || req) && (c == t);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cmp_count", count, m_count);
            chk("cmp_en", en, longint'(((64'd1 << m_count) - 64'd1) & 64'hFFFF_FFFF));
            chk("cmp_busy", busy, (m_count != m_tgt));
            chk("cmp_ack", ack, m_ack);
            chk("cmp_done", done, m_done);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req_pulse(input int t);
        target = 6'(t); req = 1'b1;
        cyc(1);
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        nerr++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; target = '0; droop = 1'b0;
        req2 = 1'b0; target2 = '0; droop2 = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        cyc(2);
        rst_n = 1'b1; cmp_on = 1'b1;
        cyc(2);

        // Ramp 0 -> 8
        req_pulse(8);
        chk("up_ack", ack, 1); chk("up_busy", busy, 1); chk("up_c0", count, 0);
        cyc(3);  chk("up_c0b", count, 0);
        cyc(1);  chk("up_c1", count, 1);
        cyc(28); chk("up_c8", count, 8); chk("up_done", done, 1);
        chk("up_en", en, 32'h0000_00FF); chk("up_busy0", busy, 0);
        cyc(1);  chk("up_done0", done, 0);

        // No-op request
        req_pulse(8);
        chk("nop_ack", ack, 1); chk("nop_done", done, 1);
        chk("nop_busy", busy, 0); chk("nop_en", en, 32'h0000_00FF);
        cyc(1);  chk("nop_ack0", ack, 0);

        // Down to 4, up toward 12, reverse at 6 toward 2
        req_pulse(4);  cyc(16); chk("dn_c4", count, 4);
        req_pulse(12); cyc(8);  chk("rv_c6", count, 6);
        req_pulse(2);
        chk("rv_c6b", count, 6); chk("rv_busy", busy, 1);
        cyc(3);  chk("rv_hold", count, 6);
        cyc(1);  chk("rv_c5", count, 5);
        cyc(12); chk("rv_c2", count, 2); chk("rv_done", done, 1);
        cyc(1);

        // Request landing on the same edge as a step
        req_pulse(6);  cyc(7);  chk("co_c3", count, 3);
        req_pulse(1);  chk("co_c4", count, 4); chk("co_busy", busy, 1);
        cyc(4);  chk("co_c3b", count, 3);
        cyc(8);  chk("co_c1", count, 1); chk("co_done", done, 1);
        cyc(1);

        // Clamp: 40 -> 32
        req_pulse(40);
        cyc(123); chk("cl_c31", count, 31); chk("cl_nodone", done, 0);
        cyc(1);   chk("cl_c32", count, 32); chk("cl_en", en, 32'hFFFF_FFFF);
        chk("cl_done", done, 1); chk("cl_busy", busy, 0);
        cyc(5);   chk("cl_stay", count, 32);

        // Droop during UP freezes, during DOWN is ignored
        req_pulse(20); cyc(48); chk("dr_c20", count, 20);
        cyc(1);
        req_pulse(26); cyc(4); chk("dr_c21", count, 21);
        cyc(1);
        droop = 1'b1; cyc(10); chk("dr_frozen", count, 21);
        droop = 1'b0;
        cyc(2);  chk("dr_c21b", count, 21);
        cyc(1);  chk("dr_c22", count, 22);
        cyc(16); chk("dr_c26", count, 26); chk("dr_done", done, 1);
        req_pulse(18); cyc(4); chk("dd_c25", count, 25);
        droop = 1'b1; cyc(10); chk("dd_c23", count, 23);
        droop = 1'b0;
        cyc(18); chk("dd_c18", count, 18); chk("dd_done", done, 1);

        // Async reset mid-ramp
        req_pulse(0);  cyc(72); chk("rr_c0", count, 0);
        req_pulse(10); cyc(20); chk("rr_c5", count, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_count", count, 0); chk("rr_en", en, 0); chk("rr_busy", busy, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);  chk("rr_idle", count, 0); chk("rr_busy0", busy, 0);
        req_pulse(3); chk("rr_ack", ack, 1);
        cyc(12); chk("rr_c3", count, 3); chk("rr_done", done, 1);

        // STEP_CYC = 1 instance, target above bank size
        target2 = 4'd12; req2 = 1'b1;
        cyc(1);
        req2 = 1'b0;
        chk("s1_ack", ack2, 1); chk("s1_c0", count2, 0); chk("s1_busy", busy2, 1);
        cyc(1);  chk("s1_c1", count2, 1);
        cyc(1);  chk("s1_c2", count2, 2);
        cyc(6);  chk("s1_c8", count2, 8); chk("s1_en", en2, 8'hFF); chk("s1_done", done2, 1);
        cyc(1);  chk("s1_done0", done2, 0);

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
